// File: rtl/dm_access_pkg.sv
`default_nettype none
// ============================================================================
// dm_access_pkg : op/state encodings and decode helpers for the DM initiator
// Rev 1.0
// ============================================================================
package dm_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_subword(input op_e op);
    return (op != OP_LW) && (op != OP_SW);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_unit.sv
`default_nettype none
// ============================================================================
// dm_lane_unit : little-endian load lane extract/extend and store lane merge
// Rev 1.0
// ============================================================================
module dm_lane_unit
  import dm_access_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_merge,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd[7:0];
    case (i_off)
      2'd0:    w_byte = i_rd[7:0];
      2'd1:    w_byte = i_rd[15:8];
      2'd2:    w_byte = i_rd[23:16];
      default: w_byte = i_rd[31:24];
    endcase
    w_half = i_off[1] ? i_rd[31:16] : i_rd[15:0];

    o_load = i_rd;
    case (i_op)
      OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load = {24'h000000, w_byte};
      OP_LH:   o_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load = {16'h0000, w_half};
      default: o_load = i_rd;
    endcase

    // Sub-word stores rebuild the whole word from the captured old contents.
    o_store = i_wdata;
    case (i_op)
      OP_SB: begin
        o_store = i_merge;
        case (i_off)
          2'd0:    o_store[7:0]   = i_wdata[7:0];
          2'd1:    o_store[15:8]  = i_wdata[7:0];
          2'd2:    o_store[23:16] = i_wdata[7:0];
          default: o_store[31:24] = i_wdata[7:0];
        endcase
      end
      OP_SH: begin
        o_store = i_merge;
        if (i_off[1]) o_store[31:16] = i_wdata[15:0];
        else          o_store[15:0]  = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// dm_access_ctrl : CPU load/store to word-only DM, sub-word stores via RMW
// Rev 1.0
// ============================================================================
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        dm_re,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  localparam logic [31:0] c_DM_WORDS = 32'(DM_WORDS);

  state_e      r_state, w_next;
  op_e         r_op;
  logic [31:0] r_addr, r_wdata, r_pc, r_merge, r_rdata;
  logic        r_done, r_err;

  op_e         w_req_op;
  logic        w_accept, w_bad, w_active, w_write;
  logic [31:0] w_load, w_store;

  assign w_req_op = op_e'(req_op);
  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_bad    = is_misaligned(w_req_op, req_addr[1:0]) ||
                    ({2'b00, req_addr[31:2]} >= c_DM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_bad) begin
          if (!is_store(w_req_op))     w_next = ST_LOAD;
          else if (is_subword(w_req_op)) w_next = ST_RMW_RD;
          else                           w_next = ST_STORE;
        end
      end
      ST_RMW_RD:                    w_next = ST_RMW_WR;
      ST_LOAD, ST_STORE, ST_RMW_WR: w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_pc    <= req_pc;
      end
      if (r_state == ST_RMW_RD) r_merge <= dm_rd;
      if (r_state == ST_LOAD)   r_rdata <= w_load;
      r_done <= (w_accept && w_bad) || (r_state == ST_LOAD) ||
                (r_state == ST_STORE) || (r_state == ST_RMW_WR);
      r_err  <= w_accept && w_bad;
    end
  end

  dm_lane_unit u_lane (
    .i_op    (r_op),
    .i_off   (r_addr[1:0]),
    .i_rd    (dm_rd),
    .i_merge (r_merge),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_store)
  );

  assign w_active = (r_state != ST_IDLE);
  assign w_write  = (r_state == ST_STORE) || (r_state == ST_RMW_WR);

  // A reset landing on a write cycle must not corrupt memory.
  assign dm_we    = w_write && !reset;
  assign dm_re    = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
  assign dm_addr  = w_active ? {r_addr[31:2], 2'b00} : 32'h0;
  assign dm_wd    = w_write ? w_store : 32'h0;
  assign dm_pc    = w_active ? r_pc : 32'h0;

  assign busy     = w_active;
  assign done     = r_done;
  assign addr_err = r_err;
  assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dm_access_ctrl : directed checks of dm_access_ctrl against a DM model
// Rev 1.0
// ============================================================================
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        busy, done, addr_err, dm_re, dm_we;
  logic [31:0] rdata, dm_addr, dm_wd, dm_pc, dm_rd;

  logic [31:0] mem [0:4095];
  int          wr_count = 0;
  int          re_count = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          wr0, re0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.DM_WORDS(3072)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_pc     (dm_pc),
    .dm_rd     (dm_rd)
  );

  assign dm_rd = mem[dm_addr[13:2]];

  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr[13:2]] <= dm_wd;
      wr_count <= wr_count + 1;
    end
    if (dm_re) re_count <= re_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns at the T+1 sample point.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_sw(input logic [31:0] addr, input logic [31:0] wd);
    issue(3'd5, addr, wd, 32'h100);
    step();
    check("sw_done", {31'b0, done}, 32'h1);
  endtask

  typedef struct { logic [2:0] op; logic [31:0] addr; logic [31:0] exp; } ld_vec_t;
  typedef struct { logic [2:0] op; logic [31:0] addr; } err_vec_t;

  ld_vec_t  ld_tab [7];
  err_vec_t er_tab [4];

  initial begin
    ld_tab[0] = '{3'd3, 32'h12, 32'hFFFFFF80};
    ld_tab[1] = '{3'd4, 32'h12, 32'h00000080};
    ld_tab[2] = '{3'd1, 32'h12, 32'h00000080};
    ld_tab[3] = '{3'd1, 32'h10, 32'hFFFFFF00};
    ld_tab[4] = '{3'd2, 32'h10, 32'h0000FF00};
    ld_tab[5] = '{3'd3, 32'h11, 32'hFFFFFFFF};
    ld_tab[6] = '{3'd0, 32'h10, 32'h0080FF00};
    er_tab[0] = '{3'd1, 32'h13};
    er_tab[1] = '{3'd5, 32'h02};
    er_tab[2] = '{3'd0, 32'h3000};
    er_tab[3] = '{3'd7, 32'h3001};

    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy",  {31'b0, busy},     32'h0);
    check("rst_done",  {31'b0, done},     32'h0);
    check("rst_err",   {31'b0, addr_err}, 32'h0);
    check("rst_rdata", rdata,             32'h0);
    check("rst_dmre",  {31'b0, dm_re},    32'h0);
    check("rst_dmwe",  {31'b0, dm_we},    32'h0);
    check("rst_dmaddr", dm_addr,          32'h0);
    check("rst_dmwd",  dm_wd,             32'h0);
    check("rst_dmpc",  dm_pc,             32'h0);

    // SW then LW
    wr0 = wr_count;
    issue(3'd5, 32'h10, 32'hDEADBEEF, 32'h400);
    check("sw_busy",   {31'b0, busy},  32'h1);
    check("sw_we",     {31'b0, dm_we}, 32'h1);
    check("sw_re",     {31'b0, dm_re}, 32'h0);
    check("sw_addr",   dm_addr,        32'h10);
    check("sw_wd",     dm_wd,          32'hDEADBEEF);
    check("sw_pc",     dm_pc,          32'h400);
    check("sw_nodone", {31'b0, done},  32'h0);
    step();
    check("sw_done",   {31'b0, done},  32'h1);
    check("sw_idle",   {31'b0, busy},  32'h0);
    check("sw_nwr",    wr_count - wr0, 32'd1);
    check("sw_rdhold", rdata,          32'h0);
    issue(3'd0, 32'h10, 32'h0, 32'h404);
    check("lw_re",     {31'b0, dm_re}, 32'h1);
    check("lw_we",     {31'b0, dm_we}, 32'h0);
    check("lw_addr",   dm_addr,        32'h10);
    step();
    check("lw_done",   {31'b0, done},  32'h1);
    check("lw_rdata",  rdata,          32'hDEADBEEF);

    // SB read-modify-write
    run_sw(32'h10, 32'h11223344);
    wr0 = wr_count;
    issue(3'd7, 32'h11, 32'h000000A5, 32'h408);
    check("sb_rd_re",  {31'b0, dm_re}, 32'h1);
    check("sb_rd_we",  {31'b0, dm_we}, 32'h0);
    step();
    check("sb_wr_we",  {31'b0, dm_we}, 32'h1);
    check("sb_wr_wd",  dm_wd,          32'h1122A544);
    check("sb_wr_adr", dm_addr,        32'h10);
    check("sb_nodone", {31'b0, done},  32'h0);
    step();
    check("sb_done",   {31'b0, done},  32'h1);
    check("sb_mem",    mem[4],         32'h1122A544);
    check("sb_nwr",    wr_count - wr0, 32'd1);

    // Load extension
    run_sw(32'h10, 32'h0080FF00);
    for (int i = 0; i < 7; i++) begin
      issue(ld_tab[i].op, ld_tab[i].addr, 32'h0, 32'h500);
      step();
      check($sformatf("ld%0d_done", i), {31'b0, done}, 32'h1);
      check($sformatf("ld%0d_rdata", i), rdata, ld_tab[i].exp);
    end

    // Rejected accesses
    wr0 = wr_count; re0 = re_count;
    for (int i = 0; i < 4; i++) begin
      issue(er_tab[i].op, er_tab[i].addr, 32'hFFFFFFFF, 32'h600);
      check($sformatf("er%0d_done", i), {31'b0, done},     32'h1);
      check($sformatf("er%0d_err", i),  {31'b0, addr_err}, 32'h1);
      check($sformatf("er%0d_busy", i), {31'b0, busy},     32'h0);
      check($sformatf("er%0d_dm", i),   {30'b0, dm_re, dm_we}, 32'h0);
      step();
      check($sformatf("er%0d_pulse", i), {30'b0, done, addr_err}, 32'h0);
    end
    check("er_nwr",  wr_count - wr0, 32'd0);
    check("er_nre",  re_count - re0, 32'd0);
    check("er_rdhold", rdata,        32'h0080FF00);

    // Highest legal word
    run_sw(32'h2FFC, 32'h5A5A1234);
    check("top_err", {31'b0, addr_err}, 32'h0);
    issue(3'd0, 32'h2FFC, 32'h0, 32'h700);
    step();
    check("top_rdata", rdata, 32'h5A5A1234);

    // Reset during RMW write cycle
    wr0 = wr_count;
    issue(3'd6, 32'h22, 32'h0000BEEF, 32'h800);
    step();
    reset = 1'b1;
    #1;
    check("rst_we_gate", {31'b0, dm_we}, 32'h0);
    step();
    reset = 1'b0;
    check("rst_busy2",  {31'b0, busy}, 32'h0);
    check("rst_done2",  {31'b0, done}, 32'h0);
    check("rst_rdata2", rdata,         32'h0);
    check("rst_nwr",    wr_count - wr0, 32'd0);

    // Back-to-back, request held while busy
    wr0 = wr_count; re0 = re_count;
    req_op = 3'd5; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_pc = 32'h900;
    req_valid = 1'b1;
    step();
    check("b2b_busy", {31'b0, busy}, 32'h1);
    req_op = 3'd0; req_wdata = 32'h0; req_pc = 32'h904;
    step();
    check("b2b_sw_done", {31'b0, done}, 32'h1);
    check("b2b_idle",    {31'b0, busy}, 32'h0);
    step();
    req_valid = 1'b0;
    check("b2b_lw_re",  {31'b0, dm_re}, 32'h1);
    check("b2b_lw_pc",  dm_pc,          32'h904);
    step();
    check("b2b_lw_done", {31'b0, done}, 32'h1);
    check("b2b_rdata",   rdata,         32'hCAFEF00D);
    step(); step();
    check("b2b_nwr", wr_count - wr0, 32'd1);
    check("b2b_nre", re_count - re0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
